// File: rtl/inst_queue.sv
// inst_queue: fetch/decode decoupling queue replacing the IF/ID register.
// Circular buffer of DEPTH entries {pc, pcp4, inst, excp} with valid/ready
// handshakes on both sides, branch delay-slot tracking across pops, flush
// and delay-slot nullification (clrslot).
// Optional feature macro: INST_QUEUE_PASSRDY_EN lets a full queue accept a
// push in the same cycle that the head pops (adds an id_ready->if_ready path).
module inst_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int EW    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     clrslot,
    input  logic                     if_valid,
    output logic                     if_ready,
    input  logic [AW-1:0]            if_pc,
    input  logic [AW-1:0]            if_pcp4,
    input  logic [DW-1:0]            if_inst,
    input  logic [EW-1:0]            if_excp,
    input  logic                     id_ready,
    input  logic                     id_isbranch,
    output logic                     id_valid,
    output logic                     id_null,
    output logic [AW-1:0]            id_pc,
    output logic [AW-1:0]            id_pcp4,
    output logic [DW-1:0]            id_inst,
    output logic [EW-1:0]            id_excp,
    output logic                     id_inslot,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [PW:0] PTR_ONE  = (PW+1)'(1);

    typedef struct packed {
        logic [EW-1:0] excp;
        logic [DW-1:0] inst;
        logic [AW-1:0] pcp4;
        logic [AW-1:0] pc;
    } entry_t;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW:0]   wr_ptr;
    logic [PW:0]   rd_ptr;
    logic [PW-1:0] wr_idx;
    logic [PW-1:0] rd_idx;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          drop;
    logic          rd_adv;
    logic          slot_flag;
    entry_t        head;
    entry_t        mem [DEPTH];

    assign wr_idx    = wr_ptr[PW-1:0];
    assign rd_idx    = rd_ptr[PW-1:0];
    assign occupancy = wr_ptr - rd_ptr;
    assign full      = (occupancy == FULL_CNT);
    assign empty     = (occupancy == '0);

    assign id_valid  = !empty;
    assign id_null   = empty;
    assign id_inslot = slot_flag & id_valid;

    // flush overrides every other action in the cycle.
    assign pop    = id_valid & id_ready & !flush;
    // A nullified delay slot leaves the queue regardless of id_ready.
    assign drop   = clrslot & id_inslot & !flush;
    assign rd_adv = pop | drop;

`ifdef INST_QUEUE_PASSRDY_EN
    assign if_ready = !full | pop;
`else
    assign if_ready = !full;
`endif

    assign push = if_valid & if_ready & !flush;

    // Pointer update: flush empties the queue by catching rd_ptr up to wr_ptr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_adv) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Delay-slot flag: the entry after a consumed branch sits in its slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_flag <= 1'b0;
        end else if (flush || drop) begin
            slot_flag <= 1'b0;
        end else if (pop) begin
            slot_flag <= id_isbranch;
        end
    end

    // Entry storage is data only; validity comes from the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_idx] <= '{excp: if_excp, inst: if_inst, pcp4: if_pcp4, pc: if_pc};
        end
    end

    // Head read-out, forced to zero when the queue holds nothing.
    always_comb begin
        head = '0;
        if (!empty) begin
            head = mem[rd_idx];
        end
        id_pc   = head.pc;
        id_pcp4 = head.pcp4;
        id_inst = head.inst;
        id_excp = head.excp;
    end

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: reset, fill/wrap ordering, delay slot,
// clrslot drop, flush, full-queue push+pop and asynchronous reset.
module tb_inst_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int EW    = 8;
`ifdef INST_QUEUE_PASSRDY_EN
    localparam bit PASSRDY = 1'b1;
`else
    localparam bit PASSRDY = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          clrslot;
    logic          if_valid;
    logic          if_ready;
    logic [AW-1:0] if_pc;
    logic [AW-1:0] if_pcp4;
    logic [DW-1:0] if_inst;
    logic [EW-1:0] if_excp;
    logic          id_ready;
    logic          id_isbranch;
    logic          id_valid;
    logic          id_null;
    logic [AW-1:0] id_pc;
    logic [AW-1:0] id_pcp4;
    logic [DW-1:0] id_inst;
    logic [EW-1:0] id_excp;
    logic          id_inslot;
    logic [2:0]    occupancy;

    inst_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .EW(EW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .clrslot(clrslot),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc),
        .if_pcp4(if_pcp4), .if_inst(if_inst), .if_excp(if_excp),
        .id_ready(id_ready), .id_isbranch(id_isbranch), .id_valid(id_valid),
        .id_null(id_null), .id_pc(id_pc), .id_pcp4(id_pcp4),
        .id_inst(id_inst), .id_excp(id_excp), .id_inslot(id_inslot),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [AW-1:0] pcp4;
        logic [DW-1:0] inst;
        logic [EW-1:0] excp;
    } ent_t;

    ent_t sb[$];
    bit   slot_m;
    bit   last_acc;
    int   errors = 0;
    int   checks = 0;

    task automatic idle_inputs();
        flush = 0; clrslot = 0; if_valid = 0; id_ready = 0; id_isbranch = 0;
        if_pc = '0; if_pcp4 = '0; if_inst = '0; if_excp = '0;
    endtask

    task automatic set_push(input logic [AW-1:0] pc);
        if_valid = 1;
        if_pc    = pc;
        if_pcp4  = pc + 32'd4;
        if_inst  = {pc[15:0], 16'hC3A5};
        if_excp  = pc[9:2];
    endtask

    function automatic bit exp_ready();
        bit popm;
        popm = (sb.size() != 0) && id_ready && !flush;
        return (sb.size() < DEPTH) || (PASSRDY && popm);
    endfunction

    // Advance one clock, updating the reference queue with the same decisions.
    task automatic step();
        bit   rdy_m, popm, dropm, pushm;
        ent_t e;
        popm  = (sb.size() != 0) && id_ready && !flush;
        rdy_m = exp_ready();
        dropm = clrslot && slot_m && (sb.size() != 0) && !flush;
        pushm = if_valid && rdy_m && !flush;
        e = '{pc: if_pc, pcp4: if_pcp4, inst: if_inst, excp: if_excp};
        @(posedge clk);
        if (flush) begin
            sb.delete();
            slot_m = 0;
        end else begin
            if (dropm) begin
                void'(sb.pop_front());
                slot_m = 0;
            end else if (popm) begin
                void'(sb.pop_front());
                slot_m = id_isbranch;
            end
            if (pushm) sb.push_back(e);
        end
        last_acc = pushm;
        #1;
    endtask

    task automatic fill(input logic [AW-1:0] base, input int n);
        id_ready = 0;
        for (int i = 0; i < n; i++) begin
            set_push(base + 32'(4 * i));
            step();
        end
        if_valid = 0;
    endtask

    task automatic test_reset();
        rst = 1; idle_inputs();
        #12;
        checks++; if (id_null !== 1'b1) begin errors++; $display("FAIL rst_id_null actual=%b required=1", id_null); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rst_id_valid actual=%b required=0", id_valid); end
        checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL rst_id_pc actual=%h required=0", id_pc); end
        checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL rst_if_ready actual=%b required=1", if_ready); end
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL rst_occupancy actual=%0d required=0", occupancy); end
        checks++; if (id_inslot !== 1'b0) begin errors++; $display("FAIL rst_id_inslot actual=%b required=0", id_inslot); end
        rst = 0;
        set_push(32'hBFC00000);
        if_inst = 32'h24020001;
        step();
        if_valid = 0;
        checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL first_valid actual=%b required=1", id_valid); end
        checks++; if (id_pc !== 32'hBFC00000) begin errors++; $display("FAIL first_pc actual=%h required=bfc00000", id_pc); end
        checks++; if (id_pcp4 !== 32'hBFC00004) begin errors++; $display("FAIL first_pcp4 actual=%h required=bfc00004", id_pcp4); end
        checks++; if (id_inst !== 32'h24020001) begin errors++; $display("FAIL first_inst actual=%h required=24020001", id_inst); end
        id_ready = 1;
        step();
        id_ready = 0;
        checks++; if (id_null !== 1'b1) begin errors++; $display("FAIL first_drain_null actual=%b required=1", id_null); end
    endtask

    task automatic test_fill_wrap();
        logic [AW-1:0] exp_pop, nxt;
        fill(32'h1000, 4);
        checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL full_if_ready actual=%b required=0", if_ready); end
        checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL full_occupancy actual=%0d required=4", occupancy); end
        exp_pop = 32'h1000;
        nxt     = 32'h1010;
        for (int c = 0; c < 6; c++) begin
            id_ready = 1;
            set_push(nxt);
            checks++; if (if_ready !== exp_ready()) begin errors++; $display("FAIL wrap_if_ready c=%0d actual=%b required=%b", c, if_ready, exp_ready()); end
            checks++; if (id_pc !== exp_pop) begin errors++; $display("FAIL wrap_order c=%0d actual=%h required=%h", c, id_pc, exp_pop); end
            checks++; if (sb.size() == 0 || id_inst !== sb[0].inst || id_excp !== sb[0].excp || id_pcp4 !== sb[0].pcp4) begin
                errors++; $display("FAIL wrap_payload c=%0d actual=%h/%h/%h", c, id_inst, id_excp, id_pcp4);
            end
            step();
            if (last_acc) nxt = nxt + 32'd4;
            exp_pop = exp_pop + 32'd4;
        end
        if_valid = 0;
        for (int c = 0; c < 8 && sb.size() != 0; c++) begin
            checks++; if (id_pc !== exp_pop) begin errors++; $display("FAIL drain_order c=%0d actual=%h required=%h", c, id_pc, exp_pop); end
            step();
            exp_pop = exp_pop + 32'd4;
        end
        id_ready = 0;
        checks++; if (exp_pop !== nxt) begin errors++; $display("FAIL wrap_count actual=%h required=%h", exp_pop, nxt); end
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL wrap_empty actual=%0d required=0", occupancy); end
    endtask

    task automatic test_delay_slot();
        fill(32'h2000, 3);
        id_ready = 1; id_isbranch = 1;
        step();
        id_isbranch = 0;
        checks++; if (id_inslot !== 1'b1) begin errors++; $display("FAIL slot_set actual=%b required=1", id_inslot); end
        checks++; if (id_pc !== 32'h2004) begin errors++; $display("FAIL slot_head actual=%h required=2004", id_pc); end
        step();
        checks++; if (id_inslot !== 1'b0) begin errors++; $display("FAIL slot_clear actual=%b required=0", id_inslot); end
        checks++; if (id_pc !== 32'h2008) begin errors++; $display("FAIL slot_next actual=%h required=2008", id_pc); end
        step();
        id_ready = 0;
        // Repeat, nullifying the slot instruction instead of consuming it.
        fill(32'h2100, 3);
        id_ready = 1; id_isbranch = 1;
        step();
        id_ready = 0; id_isbranch = 0;
        checks++; if (id_inslot !== 1'b1) begin errors++; $display("FAIL clr_pre_slot actual=%b required=1", id_inslot); end
        clrslot = 1;
        step();
        checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL clr_occupancy actual=%0d required=1", occupancy); end
        checks++; if (id_pc !== 32'h2108) begin errors++; $display("FAIL clr_head actual=%h required=2108", id_pc); end
        checks++; if (id_inslot !== 1'b0) begin errors++; $display("FAIL clr_inslot actual=%b required=0", id_inslot); end
        step();
        clrslot = 0;
        checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL clr_noslot_occ actual=%0d required=1", occupancy); end
        id_ready = 1;
        step();
        id_ready = 0;
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL clr_drain actual=%0d required=0", occupancy); end
    endtask

    task automatic test_flush();
        fill(32'h3000, 4);
        id_ready = 1; id_isbranch = 1;
        step();
        id_ready = 0; id_isbranch = 0;
        checks++; if (id_inslot !== 1'b1 || occupancy !== 3'd3) begin
            errors++; $display("FAIL flush_setup actual=%b/%0d required=1/3", id_inslot, occupancy);
        end
        flush = 1; id_ready = 1;
        set_push(32'h3FF0);
        step();
        flush = 0; id_ready = 0; if_valid = 0;
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL flush_occupancy actual=%0d required=0", occupancy); end
        checks++; if (id_null !== 1'b1) begin errors++; $display("FAIL flush_null actual=%b required=1", id_null); end
        checks++; if (id_inslot !== 1'b0) begin errors++; $display("FAIL flush_inslot actual=%b required=0", id_inslot); end
        checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL flush_pc actual=%h required=0", id_pc); end
        step();
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL flush_push_absent actual=%0d required=0", occupancy); end
    endtask

    task automatic test_full_push_pop();
        logic [AW-1:0] exp_pop, last_pc;
        logic [2:0]    exp_occ;
        logic          rdy_req;
        fill(32'h4000, 4);
        id_ready = 1;
        set_push(32'h4010);
        rdy_req = PASSRDY;
        checks++; if (if_ready !== rdy_req) begin errors++; $display("FAIL fpp_if_ready actual=%b required=%b", if_ready, rdy_req); end
        step();
        if_valid = 0; id_ready = 0;
        exp_occ = PASSRDY ? 3'd4 : 3'd3;
        checks++; if (occupancy !== exp_occ) begin errors++; $display("FAIL fpp_occupancy actual=%0d required=%0d", occupancy, exp_occ); end
        exp_pop = 32'h4004;
        last_pc = '0;
        id_ready = 1;
        for (int c = 0; c < 8 && id_valid === 1'b1; c++) begin
            checks++; if (id_pc !== exp_pop) begin errors++; $display("FAIL fpp_order c=%0d actual=%h required=%h", c, id_pc, exp_pop); end
            last_pc = id_pc;
            step();
            exp_pop = exp_pop + 32'd4;
        end
        id_ready = 0;
        checks++; if (last_pc !== (PASSRDY ? 32'h4010 : 32'h400C)) begin
            errors++; $display("FAIL fpp_last actual=%h required=%h", last_pc, PASSRDY ? 32'h4010 : 32'h400C);
        end
    endtask

    task automatic test_async_reset();
        fill(32'h5000, 2);
        id_ready = 1;
        #2;
        rst = 1;
        #1;
        checks++; if (id_valid !== 1'b0 || id_null !== 1'b1) begin errors++; $display("FAIL arst_valid actual=%b/%b required=0/1", id_valid, id_null); end
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL arst_occupancy actual=%0d required=0", occupancy); end
        checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL arst_if_ready actual=%b required=1", if_ready); end
        checks++; if (id_pc !== 32'h0 || id_inst !== 32'h0 || id_excp !== 8'h0 || id_pcp4 !== 32'h0) begin
            errors++; $display("FAIL arst_data actual=%h/%h/%h/%h required=0", id_pc, id_pcp4, id_inst, id_excp);
        end
        sb.delete();
        slot_m = 0;
        #1;
        rst = 0;
        idle_inputs();
        step();
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL arst_after actual=%0d required=0", occupancy); end
    endtask

    initial begin
        test_reset();
        test_fill_wrap();
        test_delay_slot();
        test_flush();
        test_full_push_pop();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/inst_queue.md
# inst_queue

Parametrised fetch/decode decoupling queue that replaces the single-entry IF/ID pipeline register. It buffers up to DEPTH fetched instructions with their PC, PC+4 and exception code, and presents the oldest entry to ID. It uses a valid/ready handshake on both sides instead of a global stall. It tracks the branch delay slot across pops and supports flush and delay-slot nullification (clrslot).

## Interface
- DEPTH, 4, number of entries; power of two, ≥2
- AW, 32, address width (pc, pcp4)
- DW, 32, instruction width
- EW, 8, exception code width; code 0 = no exception
- clk  in  1  clock
- rst  in  1  reset rst, asynchronous, active-high
- flush  in  1  discard all entries and the slot flag
- clrslot  in  1  nullify the head entry if it is a delay-slot instruction
- if_valid  in  1  IF offers an entry
- if_ready  out  1  queue accepts an entry this cycle
- if_pc / if_pcp4  in  AW  fetched PC / PC+4
- if_inst  in  DW  fetched instruction
- if_excp  in  EW  fetch exception code
- id_ready  in  1  ID consumes the head entry this cycle
- id_isbranch  in  1  head entry being consumed is a branch/jump
- id_valid  out  1  head entry present
- id_null  out  1  equals !id_valid
- id_pc / id_pcp4  out  AW  head PC / PC+4; 0 when empty
- id_inst  out  DW  head instruction; 0 when empty
- id_excp  out  EW  head exception; 0 when empty
- id_inslot  out  1  head entry is a branch delay slot
- occupancy  out  log2(DEPTH)+1  current entry count

## Operation
- Storage is a circular buffer. wr_ptr and rd_ptr are log2(DEPTH)+1 bits and wrap naturally. occupancy = wr_ptr − rd_ptr (modular). full = occupancy==DEPTH. empty = occupancy==0.
- push = if_valid & if_ready & !flush. pop = id_valid & id_ready & !flush.
- Simultaneous push and pop: occupancy is unchanged and both pointers advance.
- slot_flag register:
  - Set on a pop with id_isbranch=1.
  - Cleared on any other pop.
  - Cleared on flush.
- id_inslot = slot_flag & id_valid.
- clrslot with id_inslot=1 (and no flush):
  - Head entry is dropped (rd_ptr advances) and slot_flag clears.
  - id_ready is ignored that cycle.
  - clrslot with id_inslot=0 has no effect.
- flush has priority over everything:
  - Pointers are set equal (rd_ptr <= wr_ptr), slot_flag clears, the same-cycle push is discarded.
  - Next cycle: id_valid=0, occupancy=0.
- Output data is muxed to zero when empty.
- rst: pointers 0, slot_flag 0. Outputs: id_valid 0, id_null 1, id_pc/id_pcp4/id_inst/id_excp 0, id_inslot 0, if_ready 1, occupancy 0.
- rst mid-operation discards all contents immediately (asynchronous).

## Timing
- Push at edge N: the entry is visible at the head from cycle N+1 if the queue was empty. Minimum IF→ID latency is 1 cycle.
- Pop/drop at edge N: the next entry is at the head in cycle N+1.
- id_* outputs are driven from registers/storage through the empty mux only; there is no combinational path from if_* to id_*.
- if_ready = !full by default, with no dependence on id_ready.
- Sustained throughput is 1 entry/cycle when neither side stalls.

## Configuration
- INST_QUEUE_PASSRDY_EN
  - Defined: if_ready = !full | (id_valid & id_ready & !flush). A push into a full queue is accepted when the head pops in the same cycle. This adds a combinational id_ready→if_ready path.
  - Undefined: if_ready = !full. A full queue refuses pushes regardless of pop.

## Test plan
- Reset then idle:
  - id_null=1, id_valid=0, id_pc=0, if_ready=1, occupancy=0.
  - Push pc=0xBFC00000, inst=0x24020001 → next cycle id_valid=1, id_pc=0xBFC00000, id_pcp4=0xBFC00004.
- Fill and wrap (DEPTH=4, id_ready=0):
  - Push 4 entries → if_ready=0, occupancy=4.
  - Then id_ready=1 for 6 cycles with a continuous push → entries emerge in PC order across pointer wrap with no loss or duplication.
- Delay slot:
  - Pop a head with id_isbranch=1 → next head id_inslot=1.
  - Pop it → following head id_inslot=0.
  - Repeat with clrslot=1 on the slot head → it is dropped, occupancy decrements by 1, the following entry has id_inslot=0.
- Flush:
  - With 3 entries, slot_flag=1, and if_valid=1 in the same cycle, assert flush → next cycle occupancy=0, id_null=1, id_inslot=0, and the pushed entry is absent.
- Full-queue push+pop:
  - Undefined INST_QUEUE_PASSRDY_EN: if_ready=0, occupancy goes 4→3.
  - Defined: if_ready=1, occupancy stays 4, and the new entry appears last in order.
- Async reset with 2 entries mid-pop → outputs return to reset values within the same cycle as rst rising, before the next clk edge.
